// File: rtl/half_adder_unit_if.sv
// Bus bundle for half_adder_unit: operands, capture qualifier and both the
// combinational and registered results.
//
// Handshake: in_valid qualifies input_a/input_b at a rising clk edge. There
// is no ready signal and so no backpressure. out_valid is high for exactly
// the cycle after each qualified edge, and the consumer must take sum/carry
// in that cycle.
interface half_adder_unit_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             in_valid;
  logic [WIDTH-1:0] sum_now;
  logic [WIDTH-1:0] carry_now;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             out_valid;

  // Producer side: drives operands, observes results.
  modport master (
    output input_a, input_b, in_valid,
    input  sum_now, carry_now, sum, carry, out_valid
  );

  // Half-adder side: consumes operands, drives results.
  modport slave (
    input  input_a, input_b, in_valid,
    output sum_now, carry_now, sum, carry, out_valid
  );
endinterface

// File: rtl/half_adder_unit.sv
// Array of WIDTH independent half adders. Each lane gives sum = a ^ b and
// carry = a & b with no carry chain between lanes. A zero-latency
// combinational result is always available. A registered copy is also
// provided: it is captured on edges where in_valid is high and held
// otherwise, and out_valid marks the cycle after each capture.
module half_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  half_adder_unit_if.slave  bus
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_d;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid_d;
  logic             out_valid_q;

  // Per-lane half-adder equations. These are purely bitwise, so a lane never
  // sees another lane's operands.
  always_comb begin
    sum_w   = bus.input_a ^ bus.input_b;
    carry_w = bus.input_a & bus.input_b;
  end

  // Next-state: load on in_valid, otherwise hold. out_valid follows in_valid
  // by one cycle.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d   = sum_w;
      carry_d = carry_w;
    end
  end

  // Result register. The asynchronous reset clears it at once and discards
  // any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum_now   = sum_w;
  assign bus.carry_now = carry_w;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_half_adder_unit.sv
// Bench for half_adder_unit with one 1-lane instance and one 8-lane instance
// sharing clock and reset. The expected results come from adding the two
// lane bits as integers.
module tb_half_adder_unit;

  logic clk;
  logic rst_n;

  half_adder_unit_if #(.WIDTH(1)) if1 ();
  half_adder_unit_if #(.WIDTH(8)) if8 ();

  half_adder_unit #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  half_adder_unit #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int n_assert = 0;
  int n_fail   = 0;

  // Expected registered state of each instance.
  logic [63:0] e1_sum, e1_carry, e8_sum, e8_carry;
  logic        e1_v, e8_v;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each lane is a + b as an integer; bit 0 is the sum, bit 1 is the carry.
  function automatic void ref_add(input logic [63:0] a, input logic [63:0] b,
                                  input int w, output logic [63:0] s,
                                  output logic [63:0] c);
    int t;
    s = '0;
    c = '0;
    for (int i = 0; i < w; i++) begin
      t = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = t >= 2;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic a, input logic b, input logic v);
    if1.input_a  = a;
    if1.input_b  = b;
    if1.in_valid = v;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v);
    if8.input_a  = a;
    if8.input_b  = b;
    if8.in_valid = v;
  endtask

  // Advance to the next rising edge, update the model and settle 1 ns.
  task automatic tick();
    logic [63:0] s, c;
    @(posedge clk);
    if (!rst_n) begin
      e1_sum = '0; e1_carry = '0; e1_v = 1'b0;
      e8_sum = '0; e8_carry = '0; e8_v = 1'b0;
    end else begin
      if (if1.in_valid) begin
        ref_add(64'(if1.input_a), 64'(if1.input_b), 1, s, c);
        e1_sum = s; e1_carry = c;
      end
      e1_v = if1.in_valid;
      if (if8.in_valid) begin
        ref_add(64'(if8.input_a), 64'(if8.input_b), 8, s, c);
        e8_sum = s; e8_carry = c;
      end
      e8_v = if8.in_valid;
    end
    #1;
  endtask

  task automatic check_comb(input string tag);
    logic [63:0] s, c;
    ref_add(64'(if1.input_a), 64'(if1.input_b), 1, s, c);
    check({tag, "_sum_now1"},   64'(if1.sum_now),   s);
    check({tag, "_carry_now1"}, 64'(if1.carry_now), c);
    ref_add(64'(if8.input_a), 64'(if8.input_b), 8, s, c);
    check({tag, "_sum_now8"},   64'(if8.sum_now),   s);
    check({tag, "_carry_now8"}, 64'(if8.carry_now), c);
  endtask

  task automatic check_reg(input string tag);
    check({tag, "_sum1"},   64'(if1.sum),       e1_sum);
    check({tag, "_carry1"}, 64'(if1.carry),     e1_carry);
    check({tag, "_valid1"}, 64'(if1.out_valid), 64'(e1_v));
    check({tag, "_sum8"},   64'(if8.sum),       e8_sum);
    check({tag, "_carry8"}, 64'(if8.carry),     e8_carry);
    check({tag, "_valid8"}, 64'(if8.out_valid), 64'(e8_v));
  endtask

  logic [1:0] tt_in  [4];
  logic [1:0] tt_out [4];

  initial begin
    // Truth table, listed as {a,b} and {sum,carry}.
    tt_in[0]  = 2'b00; tt_in[1]  = 2'b10; tt_in[2]  = 2'b01; tt_in[3]  = 2'b11;
    tt_out[0] = 2'b00; tt_out[1] = 2'b10; tt_out[2] = 2'b10; tt_out[3] = 2'b01;

    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0);
    e1_sum = '0; e1_carry = '0; e1_v = 1'b0;
    e8_sum = '0; e8_carry = '0; e8_v = 1'b0;
    #2;
    check_reg("reset");
    #6 rst_n = 1'b1;   // release mid-cycle at t=8

    // Exhaustive combinational truth table, 50 ns per vector.
    for (int i = 0; i < 4; i++) begin
      drive1(tt_in[i][1], tt_in[i][0], 1'b0);
      #50;
      check("tt_comb_sum",   64'(if1.sum_now),   64'(tt_out[i][1]));
      check("tt_comb_carry", 64'(if1.carry_now), 64'(tt_out[i][0]));
    end

    // Registered truth table, back-to-back.
    tick();
    for (int i = 0; i < 4; i++) begin
      drive1(tt_in[i][1], tt_in[i][0], 1'b1);
      tick();
      check("tt_reg_sum",   64'(if1.sum),       64'(tt_out[i][1]));
      check("tt_reg_carry", 64'(if1.carry),     64'(tt_out[i][0]));
      check("tt_reg_valid", 64'(if1.out_valid), 64'd1);
    end

    // Hold: capture 1+1, then drop in_valid with operands 0,0.
    drive1(1'b1, 1'b1, 1'b1);
    tick();
    drive1(1'b0, 1'b0, 1'b0);
    tick();
    check("hold_sum",       64'(if1.sum),       64'd0);
    check("hold_carry",     64'(if1.carry),     64'd1);
    check("hold_valid",     64'(if1.out_valid), 64'd0);
    check("hold_sum_now",   64'(if1.sum_now),   64'd0);
    check("hold_carry_now", 64'(if1.carry_now), 64'd0);

    // Multi-lane independence.
    drive8(8'hFF, 8'h0F, 1'b1);
    tick();
    check("lane_ff0f_sum",   64'(if8.sum),   64'h00F0);
    check("lane_ff0f_carry", 64'(if8.carry), 64'h000F);
    drive8(8'hAA, 8'h55, 1'b1);
    tick();
    check("lane_aa55_sum",   64'(if8.sum),   64'h00FF);
    check("lane_aa55_carry", 64'(if8.carry), 64'h0000);
    check("lane_aa55_valid", 64'(if8.out_valid), 64'd1);

    // Random stream on both instances.
    for (int n = 0; n < 40; n++) begin
      drive1(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      #1;
      check_comb("rnd");
      tick();
      check_reg("rnd");
    end

    // Asynchronous reset mid-cycle while holding out_valid=1, carry=1.
    drive1(1'b1, 1'b1, 1'b1);
    drive8(8'hF0, 8'h3C, 1'b1);
    tick();
    check_reg("pre_rst");
    drive1(1'b0, 1'b1, 1'b1);
    drive8(8'h5A, 8'hC3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    e1_sum = '0; e1_carry = '0; e1_v = 1'b0;
    e8_sum = '0; e8_carry = '0; e8_v = 1'b0;
    check_reg("async_rst");
    check_comb("in_rst");
    tick();   // edge with in_valid=1 during reset: not captured
    check_reg("rst_edge");
    check_comb("in_rst2");

    // Release mid-cycle, then capture a=1,b=0.
    #3 rst_n = 1'b1;
    drive1(1'b1, 1'b0, 1'b1);
    drive8(8'h01, 8'h00, 1'b1);
    tick();
    check("rel_sum",   64'(if1.sum),       64'd1);
    check("rel_carry", 64'(if1.carry),     64'd0);
    check("rel_valid", 64'(if1.out_valid), 64'd1);
    check_reg("rel");
    drive1(1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0);
    tick();
    check_reg("rel_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
